input_conditioner: RTL and testbench
====================================

# input_conditioner

Front-end stage that turns the raw player buttons into the clean control signals the game controller consumes. It synchronizes each raw button into `clk`, debounces it, and resolves left/right conflicts. It produces held levels for movement and shield, and single-cycle press pulses for jump, attack and select. Attack pulses are rate-limited by a cooldown timer, and all gameplay outputs are gated by the controller's gaming flag.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable cycles required to accept a button change; legal range 2..2^20.
- `COOLDOWN_CYCLES`, default 6250000: minimum spacing between accepted attack pulses; legal range 1..2^24.
- `REPEAT_CYCLES`, default 12500000: hold-to-repeat period for attack; used only with `INPUT_AUTOREPEAT_EN`.
- `RAW_ACTIVE_LOW`, default 1: 1 means a raw input reads 0 when pressed.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `i_raw_btn` in 7: raw buttons, index order {select, defend, attack, squat, jump, left, right} = [6:0]; asynchronous to `clk`.
- `i_is_gaming` in 1: high while the game is in the play state.
- `o_right`, `o_left`, `o_squat`, `o_defend` out 1 each: debounced held levels.
- `o_jump`, `o_attack`, `o_select` out 1 each: one-cycle press pulses.

## Operation
- Polarity: each raw bit is XORed with `RAW_ACTIVE_LOW`, so internally 1 = pressed.
- Synchronizer: a 2-flop synchronizer on each bit feeds the debouncer.
- Debouncer, one per bit: holds a `stable` bit and a counter.
  - When the synchronized value equals `stable`, the counter clears.
  - Otherwise the counter increments. When it would reach `DEBOUNCE_CYCLES`, `stable` takes the new value and the counter clears.
- Press edge: `stable` rises (registered previous value is 0, current value is 1).
- Levels:
  - `o_squat` and `o_defend` = `stable` AND `i_is_gaming`.
  - `o_right` = stable_right AND NOT stable_left AND `i_is_gaming`.
  - `o_left` = stable_left AND NOT stable_right AND `i_is_gaming`.
  - Both directions pressed → both outputs 0.
- `o_jump`: press edge of jump AND `i_is_gaming`.
- `o_select`: press edge of select, regardless of `i_is_gaming`. It is needed in the start, win and lose states.
- Attack FSM, states IDLE and COOL:
  - IDLE: a press edge while `i_is_gaming` → `o_attack` pulses, cooldown counter loads `COOLDOWN_CYCLES-1`, go to COOL.
  - COOL: the counter decrements each cycle. Press edges are dropped, not queued. At counter 0, go to IDLE on the next cycle.
  - `i_is_gaming` low in any state → IDLE, counter cleared, no pulse.
- Counter widths are sized with `$clog2` of the respective parameter. No counter wraps; each saturates or clears as described.

## Timing
- Reset: all outputs 0, all `stable` bits 0 (released), all counters 0, synchronizer flops 0, FSM in IDLE.
  - Reset asserted mid-press: the button is treated as released after reset. A still-held button produces a press edge once it has been debounced again.
- Latency: a raw change sampled at edge 1 reaches `stable` at edge `DEBOUNCE_CYCLES+2`. The registered outputs change at edge `DEBOUNCE_CYCLES+3`.
- Pulses are exactly one cycle wide. A button held indefinitely produces one pulse, except attack when `INPUT_AUTOREPEAT_EN` is defined.
- A glitch shorter than `DEBOUNCE_CYCLES` synchronized cycles produces no output change.
- `i_is_gaming` gates combinationally into the output registers: a change at edge n takes effect on the outputs at edge n+1.

## Configuration
- `INPUT_AUTOREPEAT_EN` defined:
  - While attack `stable` stays 1 and `i_is_gaming` is high, IDLE re-fires `o_attack` every `REPEAT_CYCLES` after the previous pulse.
  - The effective period is max(`REPEAT_CYCLES`, `COOLDOWN_CYCLES`).
  - The repeat counter clears on release.
- Not defined: the repeat logic is absent. Attack fires only on press edges.

## Test plan
Parameters for the bench: `DEBOUNCE_CYCLES`=4, `COOLDOWN_CYCLES`=8, `REPEAT_CYCLES`=16, `RAW_ACTIVE_LOW`=1.
- Reset, then all raw bits 1 (released) for 20 cycles → every output stays 0.
- `i_is_gaming`=1, raw right driven 0 at edge 1 and held → `o_right`=1 from edge 7 onward. Release → `o_right`=0 seven cycles later.
- Raw jump low for 3 cycles only → `o_jump` never asserts. Low for 10 cycles → exactly one `o_jump` pulse, at edge 7.
- Left and right held together, gaming=1 → `o_left`=`o_right`=0. Release left → `o_right`=1 seven cycles later.
- Attack pressed, released, then pressed again 5 cycles after the first pulse → only one `o_attack` pulse. A press after 8+ cycles → a second pulse. With `INPUT_AUTOREPEAT_EN` and attack held for 40 cycles → pulses at edges 7, 23 and 39.
- `i_is_gaming`=0 and select pressed → one `o_select` pulse. Attack, jump and defend outputs stay 0.

Source files
------------

// File: rtl/input_conditioner.sv
// input_conditioner
// -----------------
// Turns the seven raw player buttons into clean game controls:
//   raw -> polarity fix -> 2-flop synchronizer -> per-button debouncer
//       -> registered levels / press pulses, gated by i_is_gaming.
// Attack press pulses are rate-limited by a two-state cooldown FSM.
//
// Optional feature macro: INPUT_AUTOREPEAT_EN
//   When defined, holding attack re-fires o_attack every REPEAT_CYCLES
//   after the previous pulse (never faster than the cooldown allows).
//   When undefined, the repeat logic is absent and attack fires on press
//   edges only.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles needed to accept a change (2..2^20)
//   COOLDOWN_CYCLES  minimum attack pulse spacing (1..2^24)
//   REPEAT_CYCLES    hold-to-repeat period (autorepeat builds only)
//   RAW_ACTIVE_LOW   1: a raw bit reads 0 while pressed
//
// Ports:
//   clk             system clock
//   rst             asynchronous active-high reset
//   i_raw_btn[6:0]  raw buttons {select, defend, attack, squat, jump, left, right}
//   i_is_gaming     high while the game is in the play state
//   o_right/o_left  direction levels; both 0 when both directions are held
//   o_squat/o_defend held levels
//   o_jump/o_attack one-cycle press pulses (gameplay)
//   o_select        one-cycle press pulse, not gated by i_is_gaming
//   o_attack_state  debug: current attack FSM state (0 = IDLE, 1 = COOL)

module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int COOLDOWN_CYCLES = 6250000,
  parameter int REPEAT_CYCLES   = 12500000,
  parameter bit RAW_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] i_raw_btn,
  input  logic       i_is_gaming,
  output logic       o_right,
  output logic       o_left,
  output logic       o_squat,
  output logic       o_defend,
  output logic       o_jump,
  output logic       o_attack,
  output logic       o_select,
  output logic       o_attack_state
);

  // Button indices inside the internal vectors.
  localparam int B_RIGHT  = 0;
  localparam int B_LEFT   = 1;
  localparam int B_JUMP   = 2;
  localparam int B_SQUAT  = 3;
  localparam int B_ATTACK = 4;
  localparam int B_DEFEND = 5;
  localparam int B_SELECT = 6;

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  // A cooldown of 1 still needs a one-bit counter.
  localparam int CD_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;

  // Elaboration-time parameter range checks.
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 20)) begin : g_bad_debounce
    $error("input_conditioner: DEBOUNCE_CYCLES out of range 2..2^20");
  end
  if (COOLDOWN_CYCLES < 1 || COOLDOWN_CYCLES > (1 << 24)) begin : g_bad_cooldown
    $error("input_conditioner: COOLDOWN_CYCLES out of range 1..2^24");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_repeat
    $error("input_conditioner: REPEAT_CYCLES must be at least 1");
  end

  // ---------------------------------------------------------------------------
  // Polarity normalisation and synchronizer (internally 1 = pressed)
  // ---------------------------------------------------------------------------
  logic [6:0] raw_pressed;
  logic [6:0] sync1;
  logic [6:0] sync2;

  assign raw_pressed = i_raw_btn ^ {7{RAW_ACTIVE_LOW}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_pressed;
      sync2 <= sync1;
    end
  end

  // ---------------------------------------------------------------------------
  // Debouncers: a change is accepted only after DEBOUNCE_CYCLES consecutive
  // cycles of disagreement between sync2 and the accepted value.
  // ---------------------------------------------------------------------------
  logic [6:0] stable;

  for (genvar b = 0; b < 7; b++) begin : g_db
    logic [DB_W-1:0] cnt;
    logic            stb;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= '0;
        stb <= 1'b0;
      end else if (sync2[b] == stb) begin
        cnt <= '0;
      end else if (cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        // The increment would reach DEBOUNCE_CYCLES: accept and restart.
        stb <= sync2[b];
        cnt <= '0;
      end else begin
        cnt <= cnt + DB_W'(1);
      end
    end

    assign stable[b] = stb;
  end

  // ---------------------------------------------------------------------------
  // Press edges for the pulse-type buttons
  // ---------------------------------------------------------------------------
  logic [2:0] pulse_prev;   // {select, attack, jump} accepted value last cycle
  logic       rise_jump;
  logic       rise_attack;
  logic       rise_select;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse_prev <= '0;
    end else begin
      pulse_prev <= {stable[B_SELECT], stable[B_ATTACK], stable[B_JUMP]};
    end
  end

  assign rise_jump   = stable[B_JUMP]   & ~pulse_prev[0];
  assign rise_attack = stable[B_ATTACK] & ~pulse_prev[1];
  assign rise_select = stable[B_SELECT] & ~pulse_prev[2];

  // ---------------------------------------------------------------------------
  // Optional hold-to-repeat for attack
  // ---------------------------------------------------------------------------
  logic attack_fire;
  logic rpt_due;

`ifdef INPUT_AUTOREPEAT_EN
  localparam int RP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  logic [RP_W-1:0] rpt_cnt;

  // rpt_cnt counts cycles since the last pulse while attack stays held in
  // play, saturating at REPEAT_CYCLES-1; the FSM fires once it is idle.
  assign rpt_due = stable[B_ATTACK] & (rpt_cnt == RP_W'(REPEAT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_cnt <= '0;
    end else if (attack_fire || !(stable[B_ATTACK] && i_is_gaming)) begin
      rpt_cnt <= '0;
    end else if (rpt_cnt != RP_W'(REPEAT_CYCLES - 1)) begin
      rpt_cnt <= rpt_cnt + RP_W'(1);
    end
  end
`else
  assign rpt_due = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Attack cooldown FSM
  // ---------------------------------------------------------------------------
  typedef enum logic {
    A_IDLE = 1'b0,
    A_COOL = 1'b1
  } attack_state_t;

  attack_state_t   state;
  attack_state_t   state_nxt;
  logic [CD_W-1:0] cd_cnt;
  logic [CD_W-1:0] cd_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= A_IDLE;
      cd_cnt <= '0;
    end else begin
      state  <= state_nxt;
      cd_cnt <= cd_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cd_nxt      = cd_cnt;
    attack_fire = 1'b0;
    if (!i_is_gaming) begin
      // Leaving play abandons any cooldown in progress.
      state_nxt = A_IDLE;
      cd_nxt    = '0;
    end else begin
      case (state)
        A_IDLE: begin
          if (rise_attack || rpt_due) begin
            attack_fire = 1'b1;
            state_nxt   = A_COOL;
            cd_nxt      = CD_W'(COOLDOWN_CYCLES - 1);
          end
        end
        A_COOL: begin
          // Press edges seen here are dropped, not queued.
          if (cd_cnt == '0) begin
            state_nxt = A_IDLE;
          end else begin
            cd_nxt = cd_cnt - CD_W'(1);
          end
        end
        default: begin
          state_nxt = A_IDLE;
          cd_nxt    = '0;
        end
      endcase
    end
  end

  assign o_attack_state = (state == A_COOL);

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_right  <= 1'b0;
      o_left   <= 1'b0;
      o_squat  <= 1'b0;
      o_defend <= 1'b0;
      o_jump   <= 1'b0;
      o_attack <= 1'b0;
      o_select <= 1'b0;
    end else begin
      o_right  <= stable[B_RIGHT] & ~stable[B_LEFT] & i_is_gaming;
      o_left   <= stable[B_LEFT] & ~stable[B_RIGHT] & i_is_gaming;
      o_squat  <= stable[B_SQUAT] & i_is_gaming;
      o_defend <= stable[B_DEFEND] & i_is_gaming;
      o_jump   <= rise_jump & i_is_gaming;
      o_attack <= attack_fire;
      o_select <= rise_select;
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner
// --------------------
// Bench for input_conditioner with DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=8,
// REPEAT_CYCLES=16, RAW_ACTIVE_LOW=1. A history-based reference model
// predicts every output on every edge; directed phases also check pulse
// counts and edge positions against hand-derived constants.

module tb_input_conditioner;

  localparam int D    = 4;
  localparam int C    = 8;
  localparam int R    = 16;
  localparam int MAXN = 4096;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] raw;
  logic       gaming;
  logic       o_right, o_left, o_squat, o_defend, o_jump, o_attack, o_select;
  logic       attack_state;
  logic [6:0] dut_outs;

  always #5 clk = ~clk;

  input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .COOLDOWN_CYCLES(C),
    .REPEAT_CYCLES  (R),
    .RAW_ACTIVE_LOW (1'b1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_raw_btn     (raw),
    .i_is_gaming   (gaming),
    .o_right       (o_right),
    .o_left        (o_left),
    .o_squat       (o_squat),
    .o_defend      (o_defend),
    .o_jump        (o_jump),
    .o_attack      (o_attack),
    .o_select      (o_select),
    .o_attack_state(attack_state)
  );

  // Same bit order as i_raw_btn.
  assign dut_outs = {o_select, o_defend, o_attack, o_squat, o_jump, o_left, o_right};

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  logic [6:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: per-edge history of pressed samples and accepted values.
  // A button's accepted value flips at edge n when the synchronized samples
  // of the previous D edges all disagree with it.
  // ---------------------------------------------------------------------------
  bit p_hist  [7][0:MAXN];
  bit st_hist [7][0:MAXN];
  int last_flip[7];
  int n;
  int cool_until;   // first edge at which the attack FSM is idle again
  int anchor;       // edge from which the hold-to-repeat interval is measured

  function automatic bit p_at(int b, int i);
    return (i < 1) ? 1'b0 : p_hist[b][i];
  endfunction

  function automatic bit st_at(int b, int i);
    return (i < 1) ? 1'b0 : st_hist[b][i];
  endfunction

  task automatic model_reset();
    n          = 0;
    cool_until = 0;
    anchor     = 0;
    for (int b = 0; b < 7; b++) last_flip[b] = 0;
    exp_q.delete();
  endtask

  task automatic model_edge();
    logic [6:0] e;
    bit s[7];
    bit sp[7];
    bit flip, cur, rise_a, rep, fire;
    n++;
    if (n >= MAXN) begin
      $display("FAIL model_overflow got=%0d exp<%0d", n, MAXN);
      $fatal(1);
    end
    for (int b = 0; b < 7; b++) begin
      s[b]  = st_at(b, n - 1);
      sp[b] = st_at(b, n - 2);
    end
    // Outputs registered at this edge.
    e      = '0;
    e[0]   = s[0] & ~s[1] & gaming;
    e[1]   = s[1] & ~s[0] & gaming;
    e[2]   = s[2] & ~sp[2] & gaming;
    e[3]   = s[3] & gaming;
    e[5]   = s[5] & gaming;
    e[6]   = s[6] & ~sp[6];
    rise_a = s[4] & ~sp[4];
    rep    = 1'b0;
`ifdef INPUT_AUTOREPEAT_EN
    rep    = s[4] && (n - anchor >= R);
`endif
    fire   = gaming && (n - 1 >= cool_until) && (rise_a || rep);
    e[4]   = fire;
    if (fire) begin
      cool_until = n + C;
      anchor     = n;
    end else begin
      if (!gaming) cool_until = n;
      if (!(s[4] && gaming)) anchor = n;
    end
    exp_q.push_back(e);
    // Sample and debounce at this edge.
    for (int b = 0; b < 7; b++) begin
      p_hist[b][n] = ~raw[b];
      cur  = st_at(b, n - 1);
      flip = (n - last_flip[b] >= D);
      for (int k = 1; k <= D; k++) begin
        if (p_at(b, n - 1 - k) == cur) flip = 1'b0;
      end
      st_hist[b][n] = flip ? ~cur : cur;
      if (flip) last_flip[b] = n;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks and pulse bookkeeping
  // ---------------------------------------------------------------------------
  int seen_cnt[7];
  int first_n[7];
  int last_n[7];

  task automatic clear_counts();
    for (int b = 0; b < 7; b++) begin
      seen_cnt[b] = 0;
      first_n[b]  = -1;
      last_n[b]   = -1;
    end
  endtask

  // One clock: inputs are already set (we are at a negedge).
  task automatic step();
    logic [6:0] e;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    e = exp_q.pop_front();
    check("outs", {25'd0, dut_outs}, {25'd0, e});
    for (int b = 0; b < 7; b++) begin
      if (dut_outs[b]) begin
        if (seen_cnt[b] == 0) first_n[b] = n;
        last_n[b] = n;
        seen_cnt[b]++;
      end
    end
  endtask

  task automatic steps(input int cnt);
    for (int i = 0; i < cnt; i++) step();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int base;
  int exp_rep_cnt;
  int exp_rep_last;

  initial begin
    rst    = 1'b1;
    raw    = 7'h7f;
    gaming = 1'b0;
    clear_counts();
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_outs", {25'd0, dut_outs}, 32'd0);
    check("reset_state", {31'd0, attack_state}, 32'd0);
    rst = 1'b0;

    // Idle, all released, not gaming.
    steps(20);
    check("idle_pulses", seen_cnt[0] + seen_cnt[1] + seen_cnt[2] + seen_cnt[3] +
          seen_cnt[4] + seen_cnt[5] + seen_cnt[6], 0);

    // Right press and release.
    gaming = 1'b1;
    steps(2);
    clear_counts();
    base   = n;
    raw[0] = 1'b0;
    steps(12);
    check("right_on_edge", first_n[0] - base, 7);
    base   = n;
    raw[0] = 1'b1;
    steps(12);
    check("right_off_edge", last_n[0] - base, 6);

    // Jump glitch of 3 cycles, then a 10-cycle press.
    clear_counts();
    raw[2] = 1'b0;
    steps(3);
    raw[2] = 1'b1;
    steps(12);
    check("jump_glitch", seen_cnt[2], 0);
    clear_counts();
    base   = n;
    raw[2] = 1'b0;
    steps(10);
    raw[2] = 1'b1;
    steps(12);
    check("jump_count", seen_cnt[2], 1);
    check("jump_edge", first_n[2] - base, 7);

    // Both directions held, then left released.
    clear_counts();
    raw[1:0] = 2'b00;
    steps(12);
    check("both_dirs", seen_cnt[0] + seen_cnt[1], 0);
    base   = n;
    raw[1] = 1'b1;
    steps(12);
    check("right_after_left", first_n[0] - base, 7);
    raw[0] = 1'b1;
    steps(12);

    // Attack: re-press inside cooldown is dropped, later press accepted.
    clear_counts();
    base   = n;
    raw[4] = 1'b0; steps(4);
    raw[4] = 1'b1; steps(4);
    raw[4] = 1'b0; steps(6);
    raw[4] = 1'b1; steps(6);
    raw[4] = 1'b0; steps(6);
    raw[4] = 1'b1; steps(12);
    check("attack_count", seen_cnt[4], 2);
    check("attack_first", first_n[4] - base, 7);
    check("attack_second", last_n[4] - base, 27);

    // Attack held for 40 cycles.
`ifdef INPUT_AUTOREPEAT_EN
    exp_rep_cnt  = 3;
    exp_rep_last = 39;
`else
    exp_rep_cnt  = 1;
    exp_rep_last = 7;
`endif
    clear_counts();
    base   = n;
    raw[4] = 1'b0; steps(40);
    raw[4] = 1'b1; steps(15);
    check("hold_count", seen_cnt[4], exp_rep_cnt);
    check("hold_first", first_n[4] - base, 7);
    check("hold_last", last_n[4] - base, exp_rep_last);

    // Not gaming: only select pulses.
    gaming = 1'b0;
    clear_counts();
    raw[6] = 1'b0; raw[5] = 1'b0; raw[4] = 1'b0; raw[2] = 1'b0;
    steps(10);
    raw = 7'h7f;
    steps(12);
    check("select_count", seen_cnt[6], 1);
    check("gated_outs", seen_cnt[2] + seen_cnt[4] + seen_cnt[5], 0);

    // Reset while jump is held: a fresh press edge follows once re-debounced.
    gaming = 1'b1;
    raw[2] = 1'b0;
    steps(10);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_mid_outs", {25'd0, dut_outs}, 32'd0);
    rst = 1'b0;
    model_reset();
    clear_counts();
    steps(12);
    check("reset_mid_jump", seen_cnt[2], 1);
    check("reset_mid_edge", first_n[2], 7);
    raw[2] = 1'b1;
    steps(10);

    // Randomized phase against the model.
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < 7; b++) begin
        if ($urandom_range(0, 4) == 0) raw[b] = ~raw[b];
      end
      if ($urandom_range(0, 29) == 0) gaming = ~gaming;
      step();
    end

    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
